// File: rtl/seg7_bcd_display.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a time-multiplexed
// common-anode 7-segment display. Optional build macro: SEG7_LEADING_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for value_i to differ from the last converted value (or forced)
// SHIFT | one add-3 / shift-left step per cycle, WIDTH_VALUE steps
// DONE  | publish work register to bcd_o, pulse bcd_valid_o
module seg7_bcd_display #(
    parameter int WIDTH_VALUE = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int SCAN_PERIOD = 100_000
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [WIDTH_VALUE-1:0]  value_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    bcd_valid_o,
    output logic                    busy_o,
    output logic [6:0]              seg_no,
    output logic                    dp_no,
    output logic [NUM_DIGITS-1:0]   an_no
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(WIDTH_VALUE + 1);
    localparam int PRE_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_VALUE-1:0] bin_q, bin_d;
    logic [WIDTH_VALUE-1:0] last_q, last_d;
    logic [BCD_W-1:0]       work_q, work_d, adj;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   force_q, force_d;
    logic                   busy_q, busy_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            bin_q   <= '0;
            last_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            force_q <= 1'b1;
            busy_q  <= 1'b0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        last_d  = last_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        force_d = force_q;
        busy_d  = busy_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        // Nibble-wise correction, no carry between nibbles
        adj     = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if ((value_i != last_q) || force_q) begin
                    state_d = SHIFT;
                    bin_d   = value_i;
                    last_d  = value_i;
                    work_d  = '0;
                    cnt_d   = '0;
                    force_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                {work_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH_VALUE - 1))
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = work_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            nibble;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                  lead_zero;
`endif

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i))
                nibble = bcd_q[4*i +: 4];
        end
        seg_d = seg_decode(nibble);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Blank a digit when it and every digit above it are zero; digit 0 always shows
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero & (bcd_q[4*i +: 4] == 4'h0);
            if (lead_zero && (idx_q == IDX_W'(i)))
                seg_d = 7'h7F;
        end
`endif
        an_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= 7'h7F;
        end else begin
            if (pre_q == PRE_W'(SCAN_PERIOD - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign seg_no      = seg_q;
    assign dp_no       = 1'b1;
    assign an_no       = an_q;

endmodule
